// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Source select, arbitration state and the buffered write request.
package wb_port_arbiter_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 128;

  typedef enum logic [1:0] {
    WB_SRC_PIPE,
    WB_SRC_MC,
    WB_SRC_NONE
  } wb_src_e;

  typedef enum logic {
    S_NORMAL,
    S_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending long-latency write buffer: storage, pointers, count and a CAM lookup on rd.
// Head is visible combinationally; caller must not push when full or pop when empty.
module wb_pend_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] query_rd,
  output logic              query_hit
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

  assign head_rd   = rd_mem[rptr];
  assign head_data = data_mem[rptr];

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off = PTR_W'(i) - rptr;
      if ((CNT_W'(off) < count) && (rd_mem[i] == query_rd)) query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline and a buffered long-latency unit.
// One cycle from grant to rf_we; stalls the pipeline to drain when the buffer fills or starves.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter bit ZERO_REG     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pipe_stall,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  input  logic [ADDR_W-1:0] query_rd,
  output logic              query_hit,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state, state_nxt;
  wb_src_e           grant;
  wb_req_t           sel_req;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic              wb_eff, fifo_push, fifo_pop, fifo_empty;

  assign wb_eff     = wb_valid && !(ZERO_REG && (wb_rd == '0));
  assign mc_ready   = (count != CNT_W'(DEPTH));
  // Writes to the zero register are handshaken but never occupy a slot.
  assign fifo_push  = mc_valid && mc_ready && !(ZERO_REG && (mc_rd == '0));
  assign fifo_empty = (count == '0);
  assign fifo_pop   = (grant == WB_SRC_MC);
  assign count_nxt  = count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  wb_pend_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_rd   (mc_rd),
    .push_data (mc_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .query_rd  (query_rd),
    .query_hit (query_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= (state_nxt == S_DRAIN) ? '0 : starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = '0;
    if (state == S_NORMAL && !fifo_empty && !fifo_pop) starve_nxt = starve_cnt + 1'b1;
    case (state)
      S_NORMAL:
        if (count_nxt == CNT_W'(DEPTH) || starve_nxt == SC_W'(STARVE_LIMIT)) state_nxt = S_DRAIN;
      S_DRAIN:
        if (count_nxt == '0) state_nxt = S_NORMAL;
      default: state_nxt = S_NORMAL;
    endcase
  end

  always_comb begin
    pipe_stall = 1'b0;
    grant      = WB_SRC_NONE;
    case (state)
      S_NORMAL: begin
        if (wb_eff)           grant = WB_SRC_PIPE;
        else if (!fifo_empty) grant = WB_SRC_MC;
      end
      S_DRAIN: begin
        pipe_stall = 1'b1;
        if (!fifo_empty) grant = WB_SRC_MC;
      end
      default: grant = WB_SRC_NONE;
    endcase
  end

  always_comb begin
    sel_req.rd   = wb_rd;
    sel_req.data = wb_data;
    if (grant == WB_SRC_MC) begin
      sel_req.rd   = head_rd;
      sel_req.data = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (grant != WB_SRC_NONE);
      if (grant != WB_SRC_NONE) begin
        rf_waddr <= sel_req.rd;
        rf_wdata <= sel_req.data;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && count == CNT_W'(DEPTH)));
  a_no_zero_write: assert property (@(posedge clk) disable iff (!rst_n)
    (ZERO_REG && rf_we) |-> (rf_waddr != '0));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
  localparam int DATA_W = 128, ADDR_W = 5, DEPTH = 4, STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_valid, mc_valid;
  logic [ADDR_W-1:0] wb_rd, mc_rd, query_rd;
  logic [DATA_W-1:0] wb_data, mc_data;
  logic              pipe_stall, mc_ready, query_hit, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                    .STARVE_LIMIT(STARVE_LIMIT), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .query_rd(query_rd), .query_hit(query_hit),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  // Behavioural model: pending queue, drain mode, starvation age, expected write port.
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  bit                m_drain;
  int                m_starve;
  bit                e_we;
  logic [ADDR_W-1:0] e_waddr;
  logic [DATA_W-1:0] e_wdata;

  always @(negedge clk) begin
    int n;
    bit wb_ok, do_pop, hit;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_drain = 0; m_starve = 0;
      e_we = 0; e_waddr = '0; e_wdata = '0;
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_stall", pipe_stall, 1'b0);
      chk("rst_ready", mc_ready, 1'b1);
    end else begin
      hit = 0;
      foreach (q[i]) if (q[i].rd == query_rd) hit = 1;
      chk("pipe_stall", pipe_stall, m_drain);
      chk("mc_ready", mc_ready, q.size() < DEPTH);
      chk("query_hit", query_hit, hit);
      chk("rf_we", rf_we, e_we);
      chk("rf_waddr", rf_waddr, e_waddr);
      chk("rf_wdata", rf_wdata, e_wdata);

      n      = q.size();
      wb_ok  = wb_valid && (wb_rd != 0);
      do_pop = (n > 0) && (m_drain || !wb_ok);
      e_we   = 0;
      if (do_pop) begin
        e = q.pop_front();
        e_we = 1; e_waddr = e.rd; e_wdata = e.data;
      end else if (!m_drain && wb_ok) begin
        e_we = 1; e_waddr = wb_rd; e_wdata = wb_data;
      end
      if (!m_drain) m_starve = (n > 0 && !do_pop) ? m_starve + 1 : 0;
      if (mc_valid && n < DEPTH && mc_rd != 0) begin
        e.rd = mc_rd; e.data = mc_data;
        q.push_back(e);
      end
      if (!m_drain && (q.size() == DEPTH || m_starve == STARVE_LIMIT)) begin
        m_drain = 1; m_starve = 0;
      end else if (m_drain && q.size() == 0) begin
        m_drain = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int wb_pct, mc_pct;
    rst_n = 1'b0; wb_valid = 0; wb_rd = '0; wb_data = '0;
    mc_valid = 0; mc_rd = '0; mc_data = '0; query_rd = '0;
    #1;
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_hit", query_hit, 1'b0);
    step(); step();
    rst_n = 1'b1;

    // Pipeline-only write
    wb_valid = 1; wb_rd = 5'd3; wb_data = {16{8'hA5}};
    step();
    wb_valid = 0; #1;
    chk("pipe_we", rf_we, 1'b1);
    chk("pipe_waddr", rf_waddr, 5'd3);
    chk("pipe_wdata", rf_wdata, {16{8'hA5}});
    chk("pipe_stall0", pipe_stall, 1'b0);

    // Idle-slot fill of a single long-latency result
    mc_valid = 1; mc_rd = 5'd7; mc_data = 128'h77; query_rd = 5'd7; #1;
    chk("fill_hit_push", query_hit, 1'b0);
    step();
    mc_valid = 0; #1;
    chk("fill_hit_pop", query_hit, 1'b1);
    chk("fill_we_n1", rf_we, 1'b0);
    step(); #1;
    chk("fill_we_n2", rf_we, 1'b1);
    chk("fill_waddr", rf_waddr, 5'd7);
    chk("fill_hit_after", query_hit, 1'b0);

    // Full drain while the pipeline writes every cycle
    wb_valid = 1; wb_rd = 5'd10; wb_data = 128'hD10;
    for (int i = 1; i <= 4; i++) begin
      mc_valid = 1; mc_rd = ADDR_W'(i); mc_data = 128'(i) << 8;
      step();
    end
    mc_valid = 0; #1;
    chk("drain_stall", pipe_stall, 1'b1);
    chk("drain_ready", mc_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      chk("drain_we", rf_we, 1'b1);
      chk("drain_order", rf_waddr, 128'(i));
      if (i == 1) chk("drain_ready_back", mc_ready, 1'b1);
    end
    chk("drain_exit_stall", pipe_stall, 1'b0);
    step(); #1;
    chk("drain_pipe_resume", rf_waddr, 5'd10);

    // Starvation of a single entry
    wb_rd = 5'd11; wb_data = 128'hB11;
    mc_valid = 1; mc_rd = 5'd9; mc_data = 128'h99;
    step();
    mc_valid = 0;
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      #1; chk("starve_wait", pipe_stall, 1'b0);
      step();
    end
    #1;
    chk("starve_stall", pipe_stall, 1'b1);
    step(); #1;
    chk("starve_waddr", rf_waddr, 5'd9);
    chk("starve_release", pipe_stall, 1'b0);

    // Zero register on both sides
    mc_valid = 1; mc_rd = 5'd5; mc_data = 128'h55;
    step();
    wb_rd = 5'd0; mc_rd = 5'd0; mc_data = 128'hBAD;
    step();
    mc_valid = 0; query_rd = 5'd0; #1;
    chk("zero_head_waddr", rf_waddr, 5'd5);
    chk("zero_hit", query_hit, 1'b0);
    step(); #1;
    chk("zero_no_write", rf_we, 1'b0);

    // Async reset in the middle of a drain
    wb_rd = 5'd12;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_rd = ADDR_W'(17 + i); mc_data = 128'(i);
      step();
    end
    mc_valid = 0; query_rd = 5'd19;
    step(); #1;
    chk("pre_rst_stall", pipe_stall, 1'b1);
    chk("pre_rst_hit", query_hit, 1'b1);
    rst_n = 0; #1;
    chk("arst_we", rf_we, 1'b0);
    chk("arst_stall", pipe_stall, 1'b0);
    chk("arst_ready", mc_ready, 1'b1);
    chk("arst_hit", query_hit, 1'b0);
    wb_valid = 0;
    step(); step();
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      chk("post_rst_quiet", rf_we, 1'b0);
    end

    // Randomized traffic with varying pressure
    for (int c = 0; c < 3000; c++) begin
      wb_pct = (c / 500 == 1 || c / 500 == 4) ? 100 : 40 + 10 * (c / 500);
      mc_pct = 20 + 10 * ((c / 300) % 6);
      if (!m_drain) begin
        wb_valid = ($urandom_range(0, 99) < wb_pct);
        wb_rd    = ADDR_W'($urandom_range(0, 15));
        wb_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      mc_valid = ($urandom_range(0, 99) < mc_pct);
      mc_rd    = ADDR_W'($urandom_range(0, 15));
      mc_data  = {$urandom, $urandom, $urandom, $urandom};
      query_rd = ADDR_W'($urandom_range(0, 15));
      step();
    end
    wb_valid = 0; mc_valid = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback result (output of the writeback mux);
  - a long-latency unit (memory refill / multi-cycle vector op) that returns results out of band.
- Long-latency results are buffered in a small FIFO and written in cycles where the pipeline does not write.
- On FIFO-full or starvation, the block stalls the pipeline and drains the FIFO.
- Also provides a pending-write lookup so decode can interlock on registers still owed by the long-latency unit.

Parameters:
- DATA_W, 128, write data width.
- ADDR_W, 5, register address width.
- DEPTH, 4, long-latency FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive non-granted cycles with FIFO non-empty before a forced drain.
- ZERO_REG, 1, when 1, writes to address 0 are discarded (no port use).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline has a result to write this cycle
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline result
- pipe_stall  out  1  pipeline must hold the writeback stage; wb_* stay stable while high
- mc_valid  in  1  long-latency result offered
- mc_ready  out  1  FIFO can accept (valid&&ready = push)
- mc_rd  in  ADDR_W  long-latency destination
- mc_data  in  DATA_W  long-latency result
- query_rd  in  ADDR_W  decode-stage source register lookup
- query_hit  out  1  some valid FIFO entry targets query_rd
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, state=S_NORMAL, starve_cnt=0.
  - Hence pipe_stall=0, mc_ready=1, query_hit=0.
  - Reset mid-drain discards all FIFO contents.
- FIFO:
  - mc_ready = (count != DEPTH); depends on registered count only.
  - Push and pop in the same cycle are legal (count unchanged).
  - Pointers wrap modulo DEPTH.
  - mc entries with ZERO_REG && mc_rd==0 are accepted but not stored.
- Zero register: pipeline writes with ZERO_REG && wb_rd==0 count as wb_valid=0 for arbitration.
- FSM state S_NORMAL:
  - pipe_stall=0; pipeline always wins.
  - FIFO head is popped and written only when effective wb_valid=0 and FIFO is non-empty.
  - starve_cnt increments each cycle the FIFO is non-empty and not popped; it clears on pop or when the FIFO is empty.
  - Go to S_DRAIN when, at the clock edge, the next count == DEPTH or the next starve_cnt == STARVE_LIMIT.
- FSM state S_DRAIN:
  - pipe_stall=1 (combinational from state only).
  - FIFO head popped every cycle; pipeline write not performed.
  - Pushes still accepted while not full.
  - Return to S_NORMAL when the FIFO becomes empty (next count==0); starve_cnt cleared on entry.
- Write port:
  - The granted source is registered into rf_we/rf_waddr/rf_wdata: 1-cycle latency from grant to write.
  - rf_we=0 in any cycle with no grant; waddr/wdata hold their last value.
- query_hit:
  - Combinational compare of query_rd against all valid entries.
  - An entry popped this cycle still counts as a hit; an entry pushed this cycle does not.
- Ordering:
  - FIFO entries are written in push order.
  - WAW against pipeline writes is decode's responsibility via query_hit.
- Starvation bound: no FIFO entry waits more than STARVE_LIMIT + DEPTH cycles.
- Assertions:
  - No push when mc_ready=0.
  - rf_we never asserted for address 0 when ZERO_REG=1.

Decomposition:
- Shared package (core pkg): wb_src_e {WB_SRC_PIPE, WB_SRC_MC, WB_SRC_NONE}; arb_state_e {S_NORMAL, S_DRAIN}; a wb_req_t struct {rd, data}.
- One natural sub-module: wb_pend_fifo, holding storage, pointers, count and the query_rd CAM compare.
- The arbitration FSM and the output register stay in the top level.

Test Plan:
- Pipeline only: wb_valid=1, rd=3, data=0xA5.., FIFO empty -> next cycle rf_we=1, waddr=3, wdata=0xA5..; pipe_stall=0.
- Idle slot fill: mc push rd=7 while wb_valid=0 -> push cycle N; pop and grant cycle N+1; rf_we at N+2 with waddr=7; query_hit(7)=1 only in cycles N+1..N+2 boundary as specified, then 0.
- Full drain: wb_valid held 1, push 4 entries rd=1..4 -> after the 4th push state=S_DRAIN, pipe_stall=1, mc_ready=0 for one cycle; writes 1,2,3,4 in order on 4 consecutive cycles; then pipe_stall=0 and the held pipeline write follows.
- Starvation: wb_valid held 1, single FIFO entry rd=9 -> after 8 non-granted cycles, S_DRAIN for 1 cycle, waddr=9 written, pipeline resumes.
- Zero reg: wb_rd=0 with mc entry pending -> FIFO head granted that cycle; rf_we never writes address 0; mc push rd=0 leaves count unchanged.
- Async reset while in S_DRAIN with 3 entries -> rf_we=0, pipe_stall=0, mc_ready=1, query_hit=0 immediately; nothing written after release.
